mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port of the core and shares it between two requesters: instruction fetch (IF) and load/store (MEM).
- Sequences each 1/2/4-byte access into consecutive byte cycles. Bytes are little-endian: byte k lives at addr+k.
- Sits between the fetch/LSU logic and the top-level mem_din/mem_dout/mem_a/mem_wr pins.
- Any instruction cache sits upstream, on the IF requester side.

Parameters:
ADDR_W, 32, width of all address ports; only bits 17:0 reach physical RAM.

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  reset; synchronous, active-high
rdy_in  in  1  global ready; low = pause
if_req  in  1  IF requests a 4-byte read; held high until if_done
if_addr  in  ADDR_W  fetch address
if_flush  in  1  abort any pending or in-flight IF read
if_done  out  1  one-cycle pulse; if_data valid
if_data  out  32  fetched word
mem_req  in  1  MEM request; held high until mem_done
mem_wr  in  1  1 = store, 0 = load
mem_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
mem_addr  in  ADDR_W  access address
mem_wdata  in  32  store data; low bytes used
mem_done  out  1  one-cycle pulse; load or store complete
mem_rdata  out  32  load data, zero-extended
ram_din  in  8  RAM read data; valid one cycle after ram_a
ram_dout  out  8  RAM write data
ram_a  out  ADDR_W  RAM address
ram_wr  out  1  1 = write this cycle

Behaviour:
- Reset: rst high at a posedge forces state IDLE and clears byte counter.
  - if_done=0, mem_done=0, ram_wr=0, ram_a=0, ram_dout=0, if_data=0, mem_rdata=0.
  - Reset mid-transaction abandons it: no done pulse, and ram_wr is 0 from the next cycle.
- States: IDLE, RD, WR, DONE. Byte counter cnt[1:0]; n = byte count (1, 2 or 4).
- IDLE, at edge E0 with a request pending:
  - Select the owner; latch addr, size, wdata and owner.
  - ram_a <= addr; cnt <= 0.
  - Read → RD with ram_wr=0.
  - Write → WR with ram_wr=1 and ram_dout=wdata[7:0].
- Arbitration: fixed priority, MEM over IF. if_req ignored when if_flush is high in the same cycle.
- RD, at edge Ek (k = 1..n):
  - Capture ram_din into byte k-1 of the result.
  - If k<n: ram_a <= addr+k.
  - At En: state → DONE; done/data registers loaded with the assembled word.
- WR, at edge Ek (k = 1..n-1): ram_a <= addr+k, ram_dout <= wdata byte k, ram_wr=1. At En: ram_wr <= 0, state → DONE.
- DONE: lasts exactly one cycle.
  - Owner's done = 1; all requests ignored, so a requester dropping req on seeing done is never re-accepted.
  - Next edge → IDLE.
  - Latency: done visible n cycles after the accept edge; next accept no earlier than E(n+2).
- Unused upper bytes of mem_rdata are 0. if_data/mem_rdata hold their value until the next completion for that owner.
- Address increment wraps modulo 2^ADDR_W.
- if_flush high at an edge while the owner is IF in RD: abort to IDLE, no if_done. Flush never affects MEM transactions.
- rdy_in low: all registers hold and ram_wr output is gated to 0. On resume the held ram_a is re-presented, so reads stay correct.
- Requests arriving during RD/WR/DONE wait; they are not queued beyond req level.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: one-bit last-owner register.
  - When both requests are pending in IDLE, grant goes to the requester not served last.
  - Last owner updates at each accept; reset value = IF, so MEM wins the first tie.
- Undefined: fixed MEM-over-IF priority; no last-owner register.

Test Plan:
- IF fetch at 0x100 with RAM bytes 13,05,00,00 → ram_a 0x100..0x103 on consecutive cycles, if_done pulse 4 cycles after accept, if_data=0x00000513, ram_wr never 1.
- if_req and mem_req (load word 0x200) asserted together → MEM served first, then IF accepted at E6 after MEM accept. With ARB_ROUND_ROBIN_EN, a second simultaneous tie goes to IF.
- Store half 0xBEEF to 0x20 → ram_wr=1 with (0x20, EF) then (0x21, BE), then ram_wr=0; mem_done 2 cycles after accept.
- Load byte from 0x31 containing 0xF0 → mem_rdata=0x000000F0, mem_done 1 cycle after accept.
- if_flush pulsed at second byte of fetch → no if_done, returns IDLE, a subsequent fetch at 0x104 completes normally.
- rdy_in low 3 cycles mid word-store → ram_wr=0 and ram_a frozen during pause, all 4 bytes written correctly after resume; rst during a word store → ram_wr=0 next cycle, no mem_done.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and byte-wide RAM signals of mem_arbiter, plus the global ready.
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              rdy_in;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  modport slave (
    input  rdy_in, if_req, if_addr, if_flush, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );
  modport master (
    output rdy_in, if_req, if_addr, if_flush, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between fetch and load/store, splitting accesses into byte cycles.
// Define ARB_ROUND_ROBIN_EN to break simultaneous requests in favour of the requester not served last.
module mem_arbiter #(parameter int ADDR_W = 32) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t            state;
  logic [1:0]        cnt, last, sel_last;
  logic [ADDR_W-1:0] addr, nxt_a;
  logic [31:0]       wdata, acc, nxt_acc, wsh;
  logic              own_mem, wr_q, if_pend, take_mem;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_mem;
  assign take_mem = bus.mem_req & (~if_pend | ~last_mem);
`else
  assign take_mem = bus.mem_req;
`endif
  assign if_pend  = bus.if_req & ~bus.if_flush;
  assign sel_last = bus.mem_size == 2'd0 ? 2'd0 : bus.mem_size == 2'd1 ? 2'd1 : 2'd3;
  assign nxt_acc  = acc | ({24'b0, bus.ram_din} << {cnt, 3'b000});
  assign nxt_a    = addr + ADDR_W'(cnt) + ADDR_W'(1);
  assign wsh      = wdata >> {cnt + 2'd1, 3'b000};
  // a pause must never let a write strobe reach the RAM
  assign bus.ram_wr = wr_q & bus.rdy_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= '0;
      addr          <= '0;
      wdata         <= '0;
      acc           <= '0;
      own_mem       <= 1'b0;
      wr_q          <= 1'b0;
      bus.ram_a     <= '0;
      bus.ram_dout  <= '0;
      bus.if_done   <= 1'b0;
      bus.mem_done  <= 1'b0;
      bus.if_data   <= '0;
      bus.mem_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem      <= 1'b0;
`endif
    end else if (bus.rdy_in) begin
      case (state)
        IDLE: if (take_mem | if_pend) begin
          own_mem   <= take_mem;
          addr      <= take_mem ? bus.mem_addr : bus.if_addr;
          bus.ram_a <= take_mem ? bus.mem_addr : bus.if_addr;
          wdata     <= bus.mem_wdata;
          last      <= take_mem ? sel_last : 2'd3;
          cnt       <= '0;
          acc       <= '0;
          wr_q      <= take_mem & bus.mem_wr;
          if (take_mem & bus.mem_wr) bus.ram_dout <= bus.mem_wdata[7:0];
          state     <= (take_mem & bus.mem_wr) ? WR : RD;
`ifdef ARB_ROUND_ROBIN_EN
          last_mem  <= take_mem;
`endif
        end
        RD: if (~own_mem & bus.if_flush) state <= IDLE;
        else if (cnt == last) begin
          state <= DONE;
          if (own_mem) begin
            bus.mem_done  <= 1'b1;
            bus.mem_rdata <= nxt_acc;
          end else begin
            bus.if_done <= 1'b1;
            bus.if_data <= nxt_acc;
          end
        end else begin
          acc       <= nxt_acc;
          cnt       <= cnt + 2'd1;
          bus.ram_a <= nxt_a;
        end
        WR: if (cnt == last) begin
          wr_q         <= 1'b0;
          state        <= DONE;
          bus.mem_done <= 1'b1;
        end else begin
          cnt          <= cnt + 2'd1;
          bus.ram_a    <= nxt_a;
          bus.ram_dout <= wsh[7:0];
        end
        default: begin
          bus.if_done  <= 1'b0;
          bus.mem_done <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter against a transaction-level schedule model and a byte RAM.
module tb_mem_arbiter;
  logic clk, rst;
  int   cyc, n_tests, n_fail, if_done_cnt, mem_done_cnt;
  logic [7:0] ram [0:4095];
  mem_arbiter_if #(.ADDR_W(32)) bus();
  mem_arbiter #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) bus.ram_din <= ram[bus.ram_a[11:0]];
  always @(posedge clk) if (bus.ram_wr === 1'b1) ram[bus.ram_a[11:0]] <= bus.ram_dout;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  // Model: each accepted access becomes a list of per-cycle expected outputs (n byte steps then one done step)
  typedef struct packed {
    logic [31:0] a; logic wr; logic [7:0] dout; logic dn_if; logic dn_mem; logic ld; logic [31:0] data; logic rd_if; logic fin;
  } step_t;
  step_t q[$];
  step_t s;
  logic [31:0] e_a, e_data_if, e_data_mem, pa, pd, ak, tmp;
  logic [7:0]  e_dout, lastb;
  logic        e_wr, e_if_done, e_mem_done, cur_if_rd, last_mem, mvalid, ifp, tm, wrf;
  int          kind, pn;
  task automatic apply(input step_t st);
    e_a = st.a; e_wr = st.wr; e_dout = st.dout; e_if_done = st.dn_if; e_mem_done = st.dn_mem;
    if (st.dn_if && st.ld) e_data_if = st.data;
    if (st.dn_mem && st.ld) e_data_mem = st.data;
    kind = st.fin ? 2 : 1;
    cur_if_rd = st.rd_if;
  endtask
  initial mvalid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      e_a = 0; e_wr = 0; e_dout = 0; e_if_done = 0; e_mem_done = 0; e_data_if = 0; e_data_mem = 0;
      kind = 0; cur_if_rd = 0; last_mem = 0; mvalid = 1;
    end else if (bus.rdy_in) begin
      if (kind == 1 && cur_if_rd && bus.if_flush) begin
        q.delete(); kind = 0; e_wr = 0;
      end else if (q.size() > 0) apply(q.pop_front());
      else if (kind == 2) begin
        kind = 0; e_if_done = 0; e_mem_done = 0;
      end else begin
        ifp = bus.if_req && !bus.if_flush;
`ifdef ARB_ROUND_ROBIN_EN
        tm = bus.mem_req && (!ifp || !last_mem);
`else
        tm = bus.mem_req;
`endif
        if (tm || ifp) begin
          pa = tm ? bus.mem_addr : bus.if_addr;
          wrf = tm && bus.mem_wr;
          pn = !tm ? 4 : bus.mem_size == 0 ? 1 : bus.mem_size == 1 ? 2 : 4;
          pd = 0; lastb = e_dout;
          for (int k = 0; k < pn; k++) begin
            ak = pa + 32'(k);
            pd |= {24'b0, ram[ak[11:0]]} << (8 * k);
            tmp = bus.mem_wdata >> (8 * k);
            if (wrf) lastb = tmp[7:0];
            q.push_back('{a: ak, wr: wrf, dout: lastb, dn_if: 0, dn_mem: 0, ld: 0, data: 0, rd_if: !tm, fin: 0});
          end
          q.push_back('{a: ak, wr: 0, dout: lastb, dn_if: !tm, dn_mem: tm, ld: !wrf, data: pd, rd_if: 0, fin: 1});
          last_mem = tm;
          apply(q.pop_front());
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (bus.if_done === 1'b1) if_done_cnt++;
    if (bus.mem_done === 1'b1) mem_done_cnt++;
    if (mvalid) begin
      chk("ram_a", bus.ram_a, e_a);
      chk("ram_wr", 32'(bus.ram_wr), 32'(e_wr && bus.rdy_in));
      chk("ram_dout", 32'(bus.ram_dout), 32'(e_dout));
      chk("if_done", 32'(bus.if_done), 32'(e_if_done));
      chk("mem_done", 32'(bus.mem_done), 32'(e_mem_done));
      chk("if_data", bus.if_data, e_data_if);
      chk("mem_rdata", bus.mem_rdata, e_data_mem);
    end
  end
  task automatic mem_op(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        output int req_cyc, output int done_cyc, output logic [31:0] rd);
    @(negedge clk);
    bus.mem_req = 1; bus.mem_wr = wr; bus.mem_size = sz; bus.mem_addr = a; bus.mem_wdata = wd;
    req_cyc = cyc + 1;
    done_cyc = -1;
    for (int i = 0; i < 60 && done_cyc < 0; i++) begin
      @(posedge clk); #1;
      if (bus.mem_done === 1'b1) done_cyc = cyc;
    end
    if (done_cyc < 0) chk("mem_timeout", 0, 1);
    rd = bus.mem_rdata;
    @(negedge clk);
    bus.mem_req = 0;
  endtask
  task automatic if_op(input logic [31:0] a, output int req_cyc, output int done_cyc, output logic [31:0] rd);
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = a;
    req_cyc = cyc + 1;
    done_cyc = -1;
    for (int i = 0; i < 60 && done_cyc < 0; i++) begin
      @(posedge clk); #1;
      if (bus.if_done === 1'b1) done_cyc = cyc;
    end
    if (done_cyc < 0) chk("if_timeout", 0, 1);
    rd = bus.if_data;
    @(negedge clk);
    bus.if_req = 0;
  endtask
  int r0, d0, r1, d1, c0;
  logic [31:0] v0, v1;
  initial begin
    cyc = 0; n_tests = 0; n_fail = 0; if_done_cnt = 0; mem_done_cnt = 0;
    rst = 1; bus.rdy_in = 1; bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.mem_req = 0; bus.mem_wr = 0; bus.mem_size = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
    ram[12'h104] = 8'h93; ram[12'h106] = 8'h10;
    ram[12'h200] = 8'h78; ram[12'h201] = 8'h56; ram[12'h202] = 8'h34; ram[12'h203] = 8'h12;
    ram[12'h031] = 8'hF0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_done", 32'(bus.if_done), 0);
    chk("rst_mem_done", 32'(bus.mem_done), 0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 0);
    chk("rst_ram_a", bus.ram_a, 0);
    chk("rst_ram_dout", 32'(bus.ram_dout), 0);
    chk("rst_if_data", bus.if_data, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    @(negedge clk);
    rst = 0;
    if_op(32'h100, r0, d0, v0);
    chk("fetch_data", v0, 32'h0000_0513);
    chk("fetch_latency", 32'(d0 - r0), 4);
    fork
      mem_op(0, 2'd2, 32'h200, 0, r0, d0, v0);
      if_op(32'h100, r1, d1, v1);
    join
    chk("tie1_mem_data", v0, 32'h1234_5678);
    chk("tie1_mem_latency", 32'(d0 - r0), 4);
    chk("tie1_if_latency", 32'(d1 - r1), 10);
    chk("tie1_if_data", v1, 32'h0000_0513);
    mem_op(1, 2'd1, 32'h20, 32'h0000_BEEF, r0, d0, v0);
    chk("store_half_latency", 32'(d0 - r0), 2);
    chk("store_half_b0", 32'(ram[12'h020]), 32'hEF);
    chk("store_half_b1", 32'(ram[12'h021]), 32'hBE);
    chk("store_half_b2", 32'(ram[12'h022]), 32'h00);
    mem_op(0, 2'd0, 32'h31, 0, r0, d0, v0);
    chk("load_byte_data", v0, 32'h0000_00F0);
    chk("load_byte_latency", 32'(d0 - r0), 1);
    fork
      mem_op(0, 2'd2, 32'h200, 0, r0, d0, v0);
      if_op(32'h104, r1, d1, v1);
    join
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie2_if_latency", 32'(d1 - r1), 4);
    chk("tie2_mem_latency", 32'(d0 - r0), 10);
`else
    chk("tie2_mem_latency", 32'(d0 - r0), 4);
    chk("tie2_if_latency", 32'(d1 - r1), 10);
`endif
    chk("tie2_if_data", v1, 32'h0010_0093);
    @(negedge clk);
    c0 = if_done_cnt;
    bus.if_req = 1; bus.if_addr = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.if_flush = 1; bus.if_req = 0;
    @(negedge clk);
    bus.if_flush = 0;
    repeat (8) @(negedge clk);
    chk("flush_no_done", 32'(if_done_cnt - c0), 0);
    if_op(32'h104, r0, d0, v0);
    chk("after_flush_data", v0, 32'h0010_0093);
    chk("after_flush_latency", 32'(d0 - r0), 4);
    fork
      mem_op(1, 2'd2, 32'h40, 32'h1122_3344, r0, d0, v0);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.rdy_in = 0;
        repeat (3) @(negedge clk);
        bus.rdy_in = 1;
      end
    join
    chk("pause_b0", 32'(ram[12'h040]), 32'h44);
    chk("pause_b1", 32'(ram[12'h041]), 32'h33);
    chk("pause_b2", 32'(ram[12'h042]), 32'h22);
    chk("pause_b3", 32'(ram[12'h043]), 32'h11);
    @(negedge clk);
    c0 = mem_done_cnt;
    bus.mem_req = 1; bus.mem_wr = 1; bus.mem_size = 2'd2; bus.mem_addr = 32'h50; bus.mem_wdata = 32'hAABB_CCDD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1; bus.mem_req = 0;
    @(posedge clk); #1;
    chk("rst_mid_ram_wr", 32'(bus.ram_wr), 0);
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_done", 32'(mem_done_cnt - c0), 0);
    chk("rst_mid_b0", 32'(ram[12'h050]), 32'hDD);
    chk("rst_mid_b2", 32'(ram[12'h052]), 32'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
